// File: rtl/core_types_pkg.sv
// Shared types for the pipeline control block: PC source select and control FSM states.
package core_types_pkg;

  localparam int unsigned PcWidth = 32;

  typedef enum logic [1:0] {
    SEQ       = 2'd0,
    DEC_REDIR = 2'd1,
    EXE_REDIR = 2'd2
  } pc_sel_t;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    MEM_WAIT   = 2'd1,
    REDIR_PEND = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/pipe_perf_counters.sv
// Pipeline performance counters: stall cycles and issued execute-stage redirects.
// Only instantiated when PIPE_PERF_COUNTERS_EN is defined. Both counters wrap.
module pipe_perf_counters #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic             stallEvent,
  input  logic             flushEvent,
  output logic [CNT_W-1:0] stallCycles,
  output logic [CNT_W-1:0] flushCount
);

  logic [CNT_W-1:0] stallQ;
  logic [CNT_W-1:0] flushQ;

  // Count events; synchronous active-low clear.
  always_ff @(posedge Clock) begin
    if (!nReset) begin
      stallQ <= '0;
      flushQ <= '0;
    end else begin
      if (stallEvent) stallQ <= stallQ + CNT_W'(1);
      if (flushEvent) flushQ <= flushQ + CNT_W'(1);
    end
  end

  assign stallCycles = stallQ;
  assign flushCount  = flushQ;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline control: redirect arbitration, stage enables/flushes, optional perf counters.
// Optional feature macro: PIPE_PERF_COUNTERS_EN (counters tie to zero when undefined).
module pipeline_ctrl
  import core_types_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic               Clock,
  input  logic               nReset,
  input  logic               flushReq,
  input  logic               branchReq,
  input  logic               holdReq,
  input  logic [PcWidth-1:0] PCnext,
  input  logic               imemReady,
  input  logic               dmemReady,
  output pc_sel_t            pcSel,
  output logic [PcWidth-1:0] pcTarget,
  output logic               enIF,
  output logic               enDEC,
  output logic               enEXE,
  output logic               flushDEC,
  output logic               flushEXE,
  output logic [CNT_W-1:0]   stallCycles,
  output logic [CNT_W-1:0]   flushCount
);

  ctrl_state_t        stateQ, stateD;
  pc_sel_t            pendSelQ, pendSelD;
  logic [PcWidth-1:0] pendTgtQ, pendTgtD;

  // Flush outranks branch whenever both pulse together.
  logic    redirAny;
  pc_sel_t redirSel;
  assign redirAny = flushReq | branchReq;
  assign redirSel = flushReq ? EXE_REDIR : DEC_REDIR;

  // State and pending-redirect registers with synchronous reset.
  always_ff @(posedge Clock) begin
    if (!nReset) begin
      stateQ   <= RUN;
      pendSelQ <= SEQ;
      pendTgtQ <= '0;
    end else begin
      stateQ   <= stateD;
      pendSelQ <= pendSelD;
      pendTgtQ <= pendTgtD;
    end
  end

  // Next-state, pending-redirect capture and stage control outputs.
  always_comb begin
    stateD   = stateQ;
    pendSelD = pendSelQ;
    pendTgtD = pendTgtQ;
    pcSel    = SEQ;
    pcTarget = '0;
    enIF     = 1'b1;
    enDEC    = 1'b1;
    enEXE    = 1'b1;
    flushDEC = 1'b0;
    flushEXE = 1'b0;

    unique case (stateQ)
      RUN: begin
        if (!dmemReady) begin
          enIF  = 1'b0;
          enDEC = 1'b0;
          enEXE = 1'b0;
          if (redirAny) begin
            pendSelD = redirSel;
            pendTgtD = PCnext;
            stateD   = REDIR_PEND;
          end else begin
            stateD = MEM_WAIT;
          end
        end else if (flushReq) begin
          flushDEC = 1'b1;
          flushEXE = 1'b1;
          if (imemReady) begin
            pcSel    = EXE_REDIR;
            pcTarget = PCnext;
          end else begin
            enIF     = 1'b0;
            pendSelD = EXE_REDIR;
            pendTgtD = PCnext;
            stateD   = REDIR_PEND;
          end
        end else if (holdReq) begin
          // Load-use: freeze IF/DEC, let EXE drain with a bubble behind it.
          enIF     = 1'b0;
          enDEC    = 1'b0;
          flushEXE = 1'b1;
        end else if (branchReq) begin
          flushDEC = 1'b1;
          if (imemReady) begin
            pcSel    = DEC_REDIR;
            pcTarget = PCnext;
          end else begin
            enIF     = 1'b0;
            pendSelD = DEC_REDIR;
            pendTgtD = PCnext;
            stateD   = REDIR_PEND;
          end
        end else if (!imemReady) begin
          enIF     = 1'b0;
          flushDEC = 1'b1;
        end
      end

      MEM_WAIT: begin
        enIF  = 1'b0;
        enDEC = 1'b0;
        enEXE = 1'b0;
        if (dmemReady) stateD = RUN;
      end

      REDIR_PEND: begin
        enIF = 1'b0;
        // A later execute redirect supersedes whatever is pending; branches are dropped.
        if (flushReq) begin
          pendSelD = EXE_REDIR;
          pendTgtD = PCnext;
        end
        if (!dmemReady) begin
          enDEC = 1'b0;
          enEXE = 1'b0;
        end else begin
          flushDEC = 1'b1;
          flushEXE = flushReq;
          if (imemReady) begin
            enIF     = 1'b1;
            pcSel    = pendSelD;
            pcTarget = pendTgtD;
            stateD   = RUN;
          end
        end
      end

      default: stateD = RUN;
    endcase

    // Outputs held at their reset values while reset is asserted.
    if (!nReset) begin
      pcSel    = SEQ;
      pcTarget = '0;
      enIF     = 1'b1;
      enDEC    = 1'b1;
      enEXE    = 1'b1;
      flushDEC = 1'b0;
      flushEXE = 1'b0;
    end
  end

`ifdef PIPE_PERF_COUNTERS_EN
  logic stallEvent;
  logic flushEvent;
  assign stallEvent = ~(enIF & enDEC & enEXE);
  assign flushEvent = (pcSel == EXE_REDIR);

  pipe_perf_counters #(
    .CNT_W(CNT_W)
  ) uPerfCounters (
    .Clock      (Clock),
    .nReset     (nReset),
    .stallEvent (stallEvent),
    .flushEvent (flushEvent),
    .stallCycles(stallCycles),
    .flushCount (flushCount)
  );
`else
  assign stallCycles = '0;
  assign flushCount  = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl. Counter expectations follow PIPE_PERF_COUNTERS_EN.
module tb_pipeline_ctrl;
  import core_types_pkg::*;

  localparam int unsigned CntW = 32;

  logic            Clock = 1'b0;
  logic            nReset;
  logic            flushReq, branchReq, holdReq;
  logic [31:0]     PCnext;
  logic            imemReady, dmemReady;
  pc_sel_t         pcSel;
  logic [31:0]     pcTarget;
  logic            enIF, enDEC, enEXE, flushDEC, flushEXE;
  logic [CntW-1:0] stallCycles, flushCount;

  logic [4:0] ctl;
  assign ctl = {enIF, enDEC, enEXE, flushDEC, flushEXE};

  typedef struct packed {
    pc_sel_t     sel;
    logic [31:0] tgt;
  } redir_t;

  redir_t expQ[$];
  int nVec = 0;
  int nMis = 0;

  pipeline_ctrl #(.CNT_W(CntW)) dut (
    .Clock      (Clock),
    .nReset     (nReset),
    .flushReq   (flushReq),
    .branchReq  (branchReq),
    .holdReq    (holdReq),
    .PCnext     (PCnext),
    .imemReady  (imemReady),
    .dmemReady  (dmemReady),
    .pcSel      (pcSel),
    .pcTarget   (pcTarget),
    .enIF       (enIF),
    .enDEC      (enDEC),
    .enEXE      (enEXE),
    .flushDEC   (flushDEC),
    .flushEXE   (flushEXE),
    .stallCycles(stallCycles),
    .flushCount (flushCount)
  );

  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic settle();
    @(negedge Clock);
  endtask

  task automatic idle_inputs();
    flushReq  = 1'b0;
    branchReq = 1'b0;
    holdReq   = 1'b0;
    PCnext    = '0;
    imemReady = 1'b1;
    dmemReady = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    nReset   = 1'b0;
    flushReq = 1'b1;
    PCnext   = 32'h0000_1234;
    tick();
    settle();
    nVec++;
    if (pcSel !== SEQ) begin
      nMis++; $display("FAIL reset_pcSel: got %0d expected %0d", pcSel, SEQ);
    end
    nVec++;
    if (pcTarget !== 32'h0) begin
      nMis++; $display("FAIL reset_pcTarget: got %h expected 0", pcTarget);
    end
    nVec++;
    if (ctl !== 5'b11100) begin
      nMis++; $display("FAIL reset_ctl: got %b expected 11100", ctl);
    end
    tick();
    flushReq = 1'b0;
    PCnext   = '0;
    settle();
    nVec++;
    if (stallCycles !== '0 || flushCount !== '0) begin
      nMis++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", stallCycles, flushCount);
    end
    tick();
    nReset = 1'b1;
    settle();
    nVec++;
    if (ctl !== 5'b11100 || pcSel !== SEQ) begin
      nMis++; $display("FAIL post_reset: got ctl %b sel %0d expected 11100 sel 0", ctl, pcSel);
    end
    tick();
  endtask

  task automatic test_flush();
    redir_t exp;
    idle_inputs();
    flushReq = 1'b1;
    PCnext   = 32'h0000_0100;
    expQ.push_back('{sel: EXE_REDIR, tgt: 32'h0000_0100});
    settle();
    exp = expQ.pop_front();
    nVec++;
    if (pcSel !== exp.sel || pcTarget !== exp.tgt) begin
      nMis++; $display("FAIL flush_redir: got %0d/%h expected %0d/%h", pcSel, pcTarget, exp.sel, exp.tgt);
    end
    nVec++;
    if (ctl !== 5'b11111) begin
      nMis++; $display("FAIL flush_ctl: got %b expected 11111", ctl);
    end
    tick();
    idle_inputs();
    settle();
    nVec++;
    if (pcSel !== SEQ || ctl !== 5'b11100) begin
      nMis++; $display("FAIL flush_after: got sel %0d ctl %b expected 0 11100", pcSel, ctl);
    end
    tick();
  endtask

  task automatic test_hold();
    idle_inputs();
    for (int c = 0; c < 2; c++) begin
      holdReq = 1'b1;
      settle();
      nVec++;
      if (ctl !== 5'b00101 || pcSel !== SEQ) begin
        nMis++; $display("FAIL hold_cycle%0d: got ctl %b sel %0d expected 00101 0", c, ctl, pcSel);
      end
      tick();
    end
    holdReq = 1'b0;
    settle();
    nVec++;
    if (ctl !== 5'b11100) begin
      nMis++; $display("FAIL hold_release: got %b expected 11100", ctl);
    end
    tick();
  endtask

  task automatic test_imem_branch();
    redir_t exp;
    idle_inputs();
    imemReady = 1'b0;
    branchReq = 1'b1;
    PCnext    = 32'h0000_0200;
    expQ.push_back('{sel: DEC_REDIR, tgt: 32'h0000_0200});
    settle();
    nVec++;
    if (pcSel !== SEQ || ctl !== 5'b01110) begin
      nMis++; $display("FAIL imem_branch_latch: got sel %0d ctl %b expected 0 01110", pcSel, ctl);
    end
    tick();
    branchReq = 1'b0;
    PCnext    = 32'hdead_beef;
    for (int c = 0; c < 2; c++) begin
      settle();
      nVec++;
      if (pcSel !== SEQ || ctl !== 5'b01110) begin
        nMis++; $display("FAIL imem_branch_wait%0d: got sel %0d ctl %b expected 0 01110", c, pcSel, ctl);
      end
      tick();
    end
    imemReady = 1'b1;
    settle();
    exp = expQ.pop_front();
    nVec++;
    if (pcSel !== exp.sel || pcTarget !== exp.tgt) begin
      nMis++; $display("FAIL imem_branch_issue: got %0d/%h expected %0d/%h", pcSel, pcTarget, exp.sel, exp.tgt);
    end
    tick();
    settle();
    nVec++;
    if (pcSel !== SEQ || ctl !== 5'b11100) begin
      nMis++; $display("FAIL imem_branch_once: got sel %0d ctl %b expected 0 11100", pcSel, ctl);
    end
    tick();
  endtask

  task automatic test_flush_overwrite();
    redir_t exp;
    idle_inputs();
    imemReady = 1'b0;
    branchReq = 1'b1;
    PCnext    = 32'h0000_0200;
    settle();
    tick();
    branchReq = 1'b0;
    flushReq  = 1'b1;
    PCnext    = 32'h0000_0300;
    expQ.push_back('{sel: EXE_REDIR, tgt: 32'h0000_0300});
    settle();
    nVec++;
    if (pcSel !== SEQ || ctl !== 5'b01111) begin
      nMis++; $display("FAIL overwrite_flush: got sel %0d ctl %b expected 0 01111", pcSel, ctl);
    end
    tick();
    flushReq  = 1'b0;
    branchReq = 1'b1;
    PCnext    = 32'h0000_0400;
    settle();
    tick();
    branchReq = 1'b0;
    PCnext    = '0;
    imemReady = 1'b1;
    settle();
    exp = expQ.pop_front();
    nVec++;
    if (pcSel !== exp.sel || pcTarget !== exp.tgt) begin
      nMis++; $display("FAIL overwrite_issue: got %0d/%h expected %0d/%h", pcSel, pcTarget, exp.sel, exp.tgt);
    end
    tick();
    for (int c = 0; c < 3; c++) begin
      settle();
      nVec++;
      if (pcSel !== SEQ) begin
        nMis++; $display("FAIL overwrite_extra%0d: got sel %0d expected 0", c, pcSel);
      end
      tick();
    end
  endtask

  task automatic test_simultaneous();
    redir_t exp;
    idle_inputs();
    flushReq  = 1'b1;
    branchReq = 1'b1;
    PCnext    = 32'h0000_0500;
    expQ.push_back('{sel: EXE_REDIR, tgt: 32'h0000_0500});
    settle();
    exp = expQ.pop_front();
    nVec++;
    if (pcSel !== exp.sel || pcTarget !== exp.tgt || ctl !== 5'b11111) begin
      nMis++; $display("FAIL simultaneous: got %0d/%h ctl %b expected %0d/%h ctl 11111", pcSel, pcTarget, ctl, exp.sel, exp.tgt);
    end
    tick();
    idle_inputs();
    settle();
    nVec++;
    if (pcSel !== SEQ || ctl !== 5'b11100) begin
      nMis++; $display("FAIL simultaneous_after: got sel %0d ctl %b expected 0 11100", pcSel, ctl);
    end
    tick();
  endtask

  task automatic test_dmem_stall();
    logic [CntW-1:0] expStall;
    logic [CntW-1:0] expFlush;
`ifdef PIPE_PERF_COUNTERS_EN
    expStall = CntW'(4);
    expFlush = CntW'(1);
`else
    expStall = '0;
    expFlush = '0;
`endif
    idle_inputs();
    nReset = 1'b0;
    tick();
    nReset = 1'b1;
    tick();
    dmemReady = 1'b0;
    holdReq   = 1'b1;
    for (int c = 0; c < 4; c++) begin
      settle();
      nVec++;
      if (ctl !== 5'b00000) begin
        nMis++; $display("FAIL dmem_stall%0d: got ctl %b expected 00000", c, ctl);
      end
      tick();
    end
    dmemReady = 1'b1;
    settle();
    nVec++;
    if (stallCycles !== expStall) begin
      nMis++; $display("FAIL stall_count: got %0d expected %0d", stallCycles, expStall);
    end
    nVec++;
    if (ctl !== 5'b00000) begin
      nMis++; $display("FAIL mem_wait_exit: got ctl %b expected 00000", ctl);
    end
    tick();
    holdReq = 1'b0;
    settle();
    nVec++;
    if (ctl !== 5'b11100) begin
      nMis++; $display("FAIL dmem_resume: got ctl %b expected 11100", ctl);
    end
    tick();
    flushReq = 1'b1;
    PCnext   = 32'h0000_0700;
    tick();
    idle_inputs();
    settle();
    nVec++;
    if (flushCount !== expFlush) begin
      nMis++; $display("FAIL flush_count: got %0d expected %0d", flushCount, expFlush);
    end
    tick();
  endtask

  task automatic test_reset_pending();
    idle_inputs();
    imemReady = 1'b0;
    branchReq = 1'b1;
    PCnext    = 32'h0000_0600;
    settle();
    tick();
    branchReq = 1'b0;
    nReset    = 1'b0;
    settle();
    nVec++;
    if (pcSel !== SEQ || ctl !== 5'b11100) begin
      nMis++; $display("FAIL reset_pend_during: got sel %0d ctl %b expected 0 11100", pcSel, ctl);
    end
    tick();
    nReset    = 1'b1;
    imemReady = 1'b1;
    for (int c = 0; c < 3; c++) begin
      settle();
      nVec++;
      if (pcSel !== SEQ || ctl !== 5'b11100) begin
        nMis++; $display("FAIL reset_pend_after%0d: got sel %0d ctl %b expected 0 11100", c, pcSel, ctl);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_flush();
    test_hold();
    test_imem_branch();
    test_flush_overwrite();
    test_simultaneous();
    test_dmem_stall();
    test_reset_pending();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
